harris_response: RTL

- Downstream consumer of the 6x6 window stage (8-bit pixels, 480-pixel lines).
- Per valid window, computes central-difference gradients over the inner 4x4, then the structure tensor sums Sxx/Syy/Sxy.
- Produces the Harris response R = det - k*trace^2 and a thresholded corner flag.
- Fixed-latency pipeline with no backpressure; feeds non-max suppression / output packing.

---
 rtl/harris_pkg.sv | 25 ++
 rtl/harris_tensor_sum.sv | 101 ++++++++++
 rtl/harris_response.sv | 129 ++++++++++++
 3 files changed

// File: rtl/harris_pkg.sv
// Shared widths and window indexing helper for the Harris corner response path.
package harris_pkg;

  localparam int PIX_W   = 8;
  localparam int WIN     = 6;
  localparam int GRAD_W  = 9;
  localparam int PROD_W  = 18;
  localparam int SUM_W   = 22;
  localparam int RESP_W  = 64;
  localparam int COORD_W = 9;

  localparam int FLAT_W  = WIN * WIN * PIX_W;  // 288-bit flattened window
  localparam int NGRAD   = 16;                 // inner 4x4 gradient sites
  localparam int SQ_W    = 17;                 // Ix^2 / Iy^2, max 65025
  localparam int PSQ_W   = 19;                 // sum of 4 squares
  localparam int PXY_W   = 20;                 // sum of 4 signed cross terms
  localparam int SXX_W   = 21;                 // Sxx / Syy, max 1040400

  // Pixel at row r (0 = top), column c (0 = left) of the flattened window.
  function automatic logic [PIX_W-1:0] pix(input logic [FLAT_W-1:0] flat,
                                           input int r, input int c);
    return flat[(r*WIN + c)*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/harris_tensor_sum.sv
// Gradients over the inner 4x4 of a 6x6 window and the structure tensor sums.
// Four register stages; the data path runs every cycle, validity is tracked
// by the parent.
module harris_tensor_sum
  import harris_pkg::*;
(
  input  logic                    clk,
  input  logic [FLAT_W-1:0]       window_flat,
  output logic [SXX_W-1:0]        sxx,
  output logic [SXX_W-1:0]        syy,
  output logic signed [SUM_W-1:0] sxy
);

  logic signed [GRAD_W-1:0] ix_d  [NGRAD];
  logic signed [GRAD_W-1:0] ix_q  [NGRAD];
  logic signed [GRAD_W-1:0] iy_d  [NGRAD];
  logic signed [GRAD_W-1:0] iy_q  [NGRAD];

  logic [SQ_W-1:0]          ixx_d [NGRAD];
  logic [SQ_W-1:0]          ixx_q [NGRAD];
  logic [SQ_W-1:0]          iyy_d [NGRAD];
  logic [SQ_W-1:0]          iyy_q [NGRAD];
  logic signed [PROD_W-1:0] ixy_d [NGRAD];
  logic signed [PROD_W-1:0] ixy_q [NGRAD];

  logic [PSQ_W-1:0]         pxx_d [4];
  logic [PSQ_W-1:0]         pxx_q [4];
  logic [PSQ_W-1:0]         pyy_d [4];
  logic [PSQ_W-1:0]         pyy_q [4];
  logic signed [PXY_W-1:0]  pxy_d [4];
  logic signed [PXY_W-1:0]  pxy_q [4];

  logic [SXX_W-1:0]         sxx_d, sxx_q;
  logic [SXX_W-1:0]         syy_d, syy_q;
  logic signed [SUM_W-1:0]  sxy_d, sxy_q;

  // S1: central differences; site k covers row k/4+1, column k%4+1.
  always_comb begin
    for (int k = 0; k < NGRAD; k++) begin
      ix_d[k] = $signed({1'b0, pix(window_flat, k/4 + 1, k%4 + 2)})
              - $signed({1'b0, pix(window_flat, k/4 + 1, k%4)});
      iy_d[k] = $signed({1'b0, pix(window_flat, k/4 + 2, k%4 + 1)})
              - $signed({1'b0, pix(window_flat, k/4,     k%4 + 1)});
    end
  end

  // S2: per-site products; squares are non-negative so the sign bit is dropped.
  always_comb begin
    for (int k = 0; k < NGRAD; k++) begin
      ixx_d[k] = SQ_W'($unsigned(PROD_W'(ix_q[k]) * PROD_W'(ix_q[k])));
      iyy_d[k] = SQ_W'($unsigned(PROD_W'(iy_q[k]) * PROD_W'(iy_q[k])));
      ixy_d[k] = PROD_W'(ix_q[k]) * PROD_W'(iy_q[k]);
    end
  end

  // S3: one partial sum per gradient row, keeping adder depth short.
  always_comb begin
    for (int g = 0; g < 4; g++) begin
      pxx_d[g] = '0;
      pyy_d[g] = '0;
      pxy_d[g] = '0;
      for (int j = 0; j < 4; j++) begin
        pxx_d[g] = pxx_d[g] + PSQ_W'(ixx_q[g*4 + j]);
        pyy_d[g] = pyy_d[g] + PSQ_W'(iyy_q[g*4 + j]);
        pxy_d[g] = pxy_d[g] + PXY_W'(ixy_q[g*4 + j]);
      end
    end
  end

  // S4: final tensor sums.
  always_comb begin
    sxx_d = '0;
    syy_d = '0;
    sxy_d = '0;
    for (int g = 0; g < 4; g++) begin
      sxx_d = sxx_d + SXX_W'(pxx_q[g]);
      syy_d = syy_d + SXX_W'(pyy_q[g]);
      sxy_d = sxy_d + SUM_W'(pxy_q[g]);
    end
  end

  // Pipeline registers; no reset needed because validity travels separately.
  always_ff @(posedge clk) begin
    ix_q  <= ix_d;
    iy_q  <= iy_d;
    ixx_q <= ixx_d;
    iyy_q <= iyy_d;
    ixy_q <= ixy_d;
    pxx_q <= pxx_d;
    pyy_q <= pyy_d;
    pxy_q <= pxy_d;
    sxx_q <= sxx_d;
    syy_q <= syy_d;
    sxy_q <= sxy_d;
  end

  assign sxx = sxx_q;
  assign syy = syy_q;
  assign sxy = sxy_q;

endmodule

// File: rtl/harris_response.sv
// Harris corner response R = det - k*trace^2 with threshold flag and beat
// coordinates. Six register stages from window to result, no backpressure.
module harris_response
  import harris_pkg::*;
#(
  parameter int                 IMG_W   = 480,
  parameter int                 IMG_H   = 480,
  parameter logic [7:0]         K_NUM   = 8'd10,
  parameter int                 K_SHIFT = 8,
  parameter logic signed [63:0] THRESH  = 64'sd1000000000
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic [FLAT_W-1:0]   window_flat,
  input  logic                window_valid,
  output logic                out_valid,
  output logic [RESP_W-1:0]   response,
  output logic                corner,
  output logic [COORD_W-1:0]  out_x,
  output logic [COORD_W-1:0]  out_y
);

  logic [SXX_W-1:0]        sxx;
  logic [SXX_W-1:0]        syy;
  logic signed [SUM_W-1:0] sxy;

  logic [RESP_W-1:0]  p_d, p_q;
  logic [RESP_W-1:0]  q_d, q_q;
  logic [RESP_W-1:0]  t2_d, t2_q;
  logic [SUM_W-1:0]   trace;
  logic [RESP_W-1:0]  kterm;
  logic [RESP_W-1:0]  resp_calc;

  logic [RESP_W-1:0]  response_d, response_q;
  logic               corner_d, corner_q;
  logic [5:0]         vchain_d, vchain_q;
  logic [COORD_W-1:0] out_x_d, out_x_q;
  logic [COORD_W-1:0] out_y_d, out_y_q;
  logic [COORD_W-1:0] next_x_d, next_x_q;
  logic [COORD_W-1:0] next_y_d, next_y_q;

  harris_tensor_sum u_tensor (
    .clk         (clk),
    .window_flat (window_flat),
    .sxx         (sxx),
    .syy         (syy),
    .sxy         (sxy)
  );

  // S5: determinant terms and squared trace, all exact in 64 bits.
  always_comb begin
    trace = SUM_W'(sxx) + SUM_W'(syy);
    p_d   = RESP_W'(sxx) * RESP_W'(syy);
    q_d   = RESP_W'(sxy) * RESP_W'(sxy);
    t2_d  = RESP_W'(trace) * RESP_W'(trace);
  end

  // S6: k-term is non-negative so a logical shift truncates toward zero;
  // the result only moves when a valid window reaches the output.
  always_comb begin
    kterm      = (RESP_W'(K_NUM) * t2_q) >> K_SHIFT;
    resp_calc  = p_q - q_q - kterm;
    response_d = response_q;
    corner_d   = corner_q;
    if (vchain_q[4]) begin
      response_d = resp_calc;
      corner_d   = $signed(resp_calc) > THRESH;
    end
  end

  // Valid shift chain plus raster coordinates of the beat being presented.
  always_comb begin
    vchain_d = {vchain_q[4:0], window_valid};
    out_x_d  = out_x_q;
    out_y_d  = out_y_q;
    next_x_d = next_x_q;
    next_y_d = next_y_q;
    if (vchain_q[4]) begin
      out_x_d = next_x_q;
      out_y_d = next_y_q;
      if (next_x_q == COORD_W'(IMG_W - 1)) begin
        next_x_d = '0;
        if (next_y_q == COORD_W'(IMG_H - 1)) begin
          next_y_d = '0;
        end else begin
          next_y_d = next_y_q + 1'b1;
        end
      end else begin
        next_x_d = next_x_q + 1'b1;
      end
    end
  end

  // Data stages S5 carry no reset; validity decides what is observed.
  always_ff @(posedge clk) begin
    p_q  <= p_d;
    q_q  <= q_d;
    t2_q <= t2_d;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vchain_q   <= '0;
      response_q <= '0;
      corner_q   <= 1'b0;
      out_x_q    <= '0;
      out_y_q    <= '0;
      next_x_q   <= '0;
      next_y_q   <= '0;
    end else begin
      vchain_q   <= vchain_d;
      response_q <= response_d;
      corner_q   <= corner_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
      next_x_q   <= next_x_d;
      next_y_q   <= next_y_d;
    end
  end

  assign out_valid = vchain_q[5];
  assign response  = response_q;
  assign corner    = corner_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

endmodule
